// File: rtl/pll_lock_sequencer.sv
// PLL start-up supervisor in the 12 MHz reference domain: pulses PLL reset, waits for a
// stable lock within a timeout, then releases the TDC core reset; re-runs on lock loss.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES  = 12,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 120,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk_12m,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             pll_resetb,
    output logic             core_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] lock_loss_count,
    output logic [2:0]       state_dbg
);

    localparam int RST_W = $clog2(RESET_CYCLES) + 1;
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic [CNT_W-1:0]   retry_inc;
    logic               pll_resetb_q, pll_resetb_d;
    logic               core_rst_n_q, core_rst_n_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               lock_s;

    assign lock_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[0], pll_locked};
        rst_cnt_d = '0;
        tmo_d     = '0;
        stb_d     = '0;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = (retry_q == CNT_MAX) ? retry_q : retry_q + 1'b1;

        case (state_q)
            S_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_WAIT_LOCK, S_STABLE: begin
                // The timeout spans both states and takes priority over stability completion.
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TMO_LAST) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? S_FAULT : S_RESET;
                end else if (state_q == S_WAIT_LOCK) begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end
                end else if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (stb_q == STB_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end else begin
                    stb_d = stb_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_RESET;
                    loss_d  = (loss_q == CNT_MAX) ? loss_q : loss_q + 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        // Outputs are decoded from the next state so they change on the same edge as the state.
        pll_resetb_d = state_d inside {S_WAIT_LOCK, S_STABLE, S_RUN};
        core_rst_n_d = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge clk_12m) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            sync_q       <= '0;
            rst_cnt_q    <= '0;
            tmo_q        <= '0;
            stb_q        <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            core_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            rst_cnt_q    <= rst_cnt_d;
            tmo_q        <= tmo_d;
            stb_q        <= stb_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            core_rst_n_q <= core_rst_n_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign core_rst_n      = core_rst_n_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: a timeline model predicts every output change (edge and value)
// for a default instance and a CNT_W=2 instance driven by the same lock waveform.
module tb_pll_lock_sequencer;

    localparam int RC = 12;
    localparam int LT = 1200;
    localparam int SC = 120;
    localparam int MR = 3;
    localparam int EW = 52;

    logic       clk_12m;
    logic       rst_n;
    logic       pll_locked;
    logic       pr_w, cr_w, rd_w, ft_w;
    logic [7:0] rt_w, ls_w;
    logic [2:0] st_w;
    logic       pr_n, cr_n, rd_n, ft_n;
    logic [1:0] rt_n, ls_n;
    logic [2:0] st_n;

    pll_lock_sequencer u_dut (
        .clk_12m(clk_12m), .rst_n(rst_n), .pll_locked(pll_locked),
        .pll_resetb(pr_w), .core_rst_n(cr_w), .ready(rd_w), .fault(ft_w),
        .retry_count(rt_w), .lock_loss_count(ls_w), .state_dbg(st_w)
    );

    pll_lock_sequencer #(.CNT_W(2)) u_dut_sat (
        .clk_12m(clk_12m), .rst_n(rst_n), .pll_locked(pll_locked),
        .pll_resetb(pr_n), .core_rst_n(cr_n), .ready(rd_n), .fault(ft_n),
        .retry_count(rt_n), .lock_loss_count(ls_n), .state_dbg(st_n)
    );

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk_12m = 1'b0;
        forever #5 clk_12m = ~clk_12m;
    end

    int cyc = 0;
    always @(posedge clk_12m) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [EW-1:0] exp_q_w[$];
    logic [EW-1:0] exp_q_n[$];
    logic [19:0] last_exp[2];
    logic [19:0] prev_obs[2];
    bit          mon_en = 0;

    // ---------------- reference model state ----------------
    int retries_m;
    int losses_m;
    int cur_w;          // edge at which pll_resetb rises for the current attempt
    int lock_rise_abs;  // edge after which pll_locked last went high
    bit lock_level;

    logic [19:0] obs_w, obs_n;
    assign obs_w = {pr_w, cr_w, rd_w, ft_w, rt_w, ls_w};
    assign obs_n = {pr_n, cr_n, rd_n, ft_n, 6'd0, rt_n, 6'd0, ls_n};

    function automatic logic [19:0] mk_vec(input bit pr, input bit cr, input bit rd,
                                           input bit ft, input int maxv);
        int r;
        int l;
        r = (retries_m > maxv) ? maxv : retries_m;
        l = (losses_m > maxv) ? maxv : losses_m;
        return {pr, cr, rd, ft, 8'(r), 8'(l)};
    endfunction

    task automatic push_ev(input int e, input bit pr, input bit cr, input bit rd, input bit ft);
        logic [19:0] v;
        v = mk_vec(pr, cr, rd, ft, 255);
        if (v !== last_exp[0]) begin
            exp_q_w.push_back({32'(e), v});
            last_exp[0] = v;
        end
        v = mk_vec(pr, cr, rd, ft, 3);
        if (v !== last_exp[1]) begin
            exp_q_n.push_back({32'(e), v});
            last_exp[1] = v;
        end
    endtask

    // ---------------- monitor ----------------
    task automatic mon_check(input int inst, input logic [19:0] obs);
        logic [EW-1:0] e;
        bit have;
        if (obs !== prev_obs[inst]) begin
            prev_obs[inst] = obs;
            have = 0;
            e = '0;
            if (inst == 0 && exp_q_w.size() > 0) begin
                e = exp_q_w.pop_front();
                have = 1;
            end else if (inst == 1 && exp_q_n.size() > 0) begin
                e = exp_q_n.pop_front();
                have = 1;
            end
            checks++;
            if (!have) begin
                failures++;
                $display("FAIL event inst=%0d unexpected change at cyc=%0d got=%h", inst, cyc, obs);
            end else if (e[EW-1:20] != 32'(cyc) || e[19:0] !== obs) begin
                failures++;
                $display("FAIL event inst=%0d got cyc=%0d vec=%h expected cyc=%0d vec=%h",
                         inst, cyc, obs, e[EW-1:20], e[19:0]);
            end
        end
    endtask

    always @(negedge clk_12m) begin
        if (mon_en) begin
            mon_check(0, obs_w);
            mon_check(1, obs_n);
        end
    end

    task automatic chk_now(input string name);
        checks += 2;
        if (obs_w !== last_exp[0]) begin
            failures++;
            $display("FAIL %s wide got=%h expected=%h", name, obs_w, last_exp[0]);
        end
        if (obs_n !== last_exp[1]) begin
            failures++;
            $display("FAIL %s sat got=%h expected=%h", name, obs_n, last_exp[1]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_12m);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) tick();
    endtask

    task automatic drive_lock(input bit v);
        pll_locked = v;
        lock_level = v;
        if (v) lock_rise_abs = cyc;
    endtask

    task automatic timeout_at(input int t);
        retries_m++;
        if (retries_m == MR) begin
            push_ev(t, 0, 0, 0, 1);
        end else begin
            push_ev(t, 0, 0, 0, 0);
            cur_w = t + RC;
            push_ev(cur_w, 1, 0, 0, 0);
        end
        wait_until(t);
    endtask

    // Lock is high: it is seen 3 edges after it is driven, then needs SC stable edges.
    task automatic finish_attempt();
        int s;
        int r;
        s = (cur_w + 1 > lock_rise_abs + 3) ? cur_w + 1 : lock_rise_abs + 3;
        r = s + SC;
        if (r < cur_w + LT) begin
            retries_m = 0;
            push_ev(r, 1, 1, 1, 0);
            wait_until(r);
        end else begin
            timeout_at(cur_w + LT);
        end
    endtask

    task automatic attempt_lock(input int l_rel);
        if (!lock_level) begin
            wait_until(cur_w + l_rel);
            drive_lock(1);
        end
        finish_attempt();
    endtask

    task automatic attempt_glitch(input int l1, input int g, input int d);
        wait_until(cur_w + l1);
        drive_lock(1);
        wait_until(cyc + g);
        drive_lock(0);
        wait_until(cyc + d);
        drive_lock(1);
        finish_attempt();
    endtask

    task automatic attempt_nolock();
        timeout_at(cur_w + LT);
    endtask

    task automatic lose_lock(input int hold, input int relock);
        int j;
        wait_until(cyc + hold);
        drive_lock(0);
        j = cyc;
        losses_m++;
        push_ev(j + 3, 0, 0, 0, 0);
        cur_w = j + 3 + RC;
        push_ev(cur_w, 1, 0, 0, 0);
        if (relock > 0) begin
            wait_until(j + relock);
            drive_lock(1);
        end
    endtask

    task automatic pulse_reset(input int e);
        wait_until(e);
        rst_n = 1'b0;
        retries_m = 0;
        losses_m = 0;
        push_ev(e + 1, 0, 0, 0, 0);
        cur_w = e + 1 + RC;
        push_ev(cur_w, 1, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        if (lock_level) lock_rise_abs = cyc;
    endtask

    task automatic lock_then_reset(input int l_rel, input int extra);
        int s;
        wait_until(cur_w + l_rel);
        drive_lock(1);
        s = lock_rise_abs + 3;
        pulse_reset(s + extra);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        pll_locked = 1'b0;
        lock_level = 0;
        lock_rise_abs = 0;
        retries_m = 0;
        losses_m = 0;
        repeat (3) tick();
        last_exp[0] = mk_vec(0, 0, 0, 0, 255);
        last_exp[1] = mk_vec(0, 0, 0, 0, 3);
        chk_now("reset_state");
        prev_obs[0] = obs_w;
        prev_obs[1] = obs_n;
        mon_en = 1;
        rst_n = 1'b1;
        cur_w = cyc + RC;
        push_ev(cur_w, 1, 0, 0, 0);

        attempt_lock(50);
        chk_now("nominal_run");

        lose_lock($urandom_range(10, 80), 1);
        attempt_lock(0);

        lose_lock($urandom_range(10, 80), 0);
        attempt_glitch($urandom_range(0, 40), 60, 3);

        for (int i = 0; i < 4; i++) begin
            lose_lock($urandom_range(5, 60),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 30)) : 0);
            attempt_lock($urandom_range(0, 200));
        end
        chk_now("loss_saturation");

        lose_lock($urandom_range(5, 60), 0);
        attempt_nolock();
        attempt_lock($urandom_range(0, 200));
        chk_now("retry_cleared");

        lose_lock($urandom_range(5, 60), 0);
        attempt_lock(LT - 3 - SC);
        attempt_lock(0);

        lose_lock($urandom_range(5, 60), 0);
        attempt_lock(LT - 4 - SC);

        lose_lock($urandom_range(5, 60), 0);
        lock_then_reset($urandom_range(0, 50), $urandom_range(10, 100));
        attempt_lock(0);
        pulse_reset(cyc + $urandom_range(5, 50));
        attempt_lock(0);
        chk_now("after_mid_resets");

        lose_lock($urandom_range(5, 60), 0);
        repeat (MR) attempt_nolock();
        wait_until(cyc + 10000);
        chk_now("fault_hold");
        pulse_reset(cyc + 1);
        attempt_lock($urandom_range(0, 100));

        wait_until(cyc + 20);
        chk_now("final_state");
        checks += 2;
        if (exp_q_w.size() != 0) begin
            failures++;
            $display("FAIL pending_events wide left=%0d expected=0", exp_q_w.size());
        end
        if (exp_q_n.size() != 0) begin
            failures++;
            $display("FAIL pending_events sat left=%0d expected=0", exp_q_n.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Supervises the 12 MHz -> 200 MHz PLL.
- Sequence: pulses the PLL reset, waits for lock with a timeout, requires lock to stay stable, then releases the core reset for the TDC datapath.
- Detects loss of lock in operation and re-runs the sequence. Declares a sticky fault after repeated lock timeouts.
- Runs entirely in the 12 MHz reference domain. The 200 MHz domain re-synchronises core_rst_n deassertion locally.

Parameters:
- RESET_CYCLES, 12, cycles pll_resetb is held low per attempt (1 us); must be >= 1.
- LOCK_TIMEOUT, 1200, max cycles from pll_resetb release to completed stability check (100 us).
- STABLE_CYCLES, 120, consecutive synchronised-lock-high cycles required before release (10 us); must be < LOCK_TIMEOUT.
- MAX_RETRIES, 3, lock timeouts tolerated before entering FAULT; must be >= 1.
- CNT_W, 8, width of status counters.

Ports:
- clk_12m  in  1  reference clock; sole clock of the block.
- rst_n  in  1  synchronous reset, active-low.
- pll_locked  in  1  raw PLL LOCK; asynchronous to clk_12m.
- pll_resetb  out  1  drives PLL RESETB; 0 holds the PLL in reset.
- core_rst_n  out  1  active-low reset for the datapath; 1 only in RUN.
- ready  out  1  1 while in RUN.
- fault  out  1  sticky; 1 in FAULT.
- retry_count  out  CNT_W  lock timeouts since last entry to RUN.
- lock_loss_count  out  CNT_W  RUN -> lock-loss events since rst_n; saturates at all-ones.

Behaviour:
- Synchroniser: pll_locked passes through 2 flops to give lock_s. All decisions use lock_s only, so there are 2 cycles of input latency. Both flops reset to 0.
- On rst_n=0 at a clock edge:
  - state=S_RESET, all timers 0, synchroniser 0.
  - pll_resetb=0, core_rst_n=0, ready=0, fault=0, retry_count=0, lock_loss_count=0.
  - Applies from any state, including mid-sequence and FAULT.
- All outputs are registered and decoded from the state register.
- S_RESET:
  - pll_resetb=0, core_rst_n=0.
  - Stays exactly RESET_CYCLES cycles, then goes to S_WAIT_LOCK.
- S_WAIT_LOCK:
  - pll_resetb=1. A timeout timer starts at 0 on entry and increments every cycle in S_WAIT_LOCK and S_STABLE.
  - lock_s=1 -> S_STABLE, stability counter=0.
- S_STABLE:
  - pll_resetb=1.
  - Stability counter increments while lock_s=1. When it reaches STABLE_CYCLES -> S_RUN.
  - lock_s=0 -> back to S_WAIT_LOCK, stability counter cleared, timeout timer NOT cleared.
- Timeout (in S_WAIT_LOCK or S_STABLE):
  - Condition: timeout timer reaches LOCK_TIMEOUT.
  - retry_count increments (saturating).
  - If the new value equals MAX_RETRIES -> S_FAULT, else -> S_RESET.
  - Priority: if timeout and stability completion occur in the same cycle, timeout wins.
- S_RUN:
  - pll_resetb=1, core_rst_n=1, ready=1.
  - retry_count cleared to 0 on entry.
  - lock_s=0 -> S_RESET, lock_loss_count increments (saturating). core_rst_n=0 and ready=0 from the next edge.
- S_FAULT:
  - pll_resetb=0, core_rst_n=0, ready=0, fault=1.
  - Terminal; only rst_n exits.
- Latency, rst_n release to ready, with the PLL locking L cycles after pll_resetb rises:
  - RESET_CYCLES + 2 (sync) + L + STABLE_CYCLES (+1 registered output).
  - Bench tolerance: +/-1 cycle, documented per implementation; exact value fixed once RTL lands.
- Counters use CNT_W bits. Timers are sized by $clog2 of their parameter + 1.

Test Plan:
- Nominal lock (default params): PLL model asserts lock 50 cycles after pll_resetb rises, stays high -> pll_resetb low exactly 12 cycles; ready=1 and core_rst_n=1 about 172 cycles after pll_resetb rises; retry_count=0, fault=0.
- Lock glitch during stabilisation: lock high 60 cycles, low 3 cycles, then high -> no RUN at the first attempt; stability restarts; ready rises 120+2 cycles after the second rising edge; retry_count=0.
- Timeout to fault: pll_locked tied 0 -> three 1212-cycle attempts; retry_count goes 1, 2, 3; fault=1 after the third timeout; pll_resetb=0; stays in FAULT 10000 cycles; rst_n pulse clears everything.
- Lock loss in RUN: drop pll_locked for 1 cycle after ready=1 -> within 3 cycles core_rst_n=0, ready=0, pll_resetb=0 for 12 cycles; lock_loss_count=1; re-lock restores ready.
- Reset mid-operation: assert rst_n=0 for 1 cycle while in S_STABLE and again in S_RUN -> next cycle all outputs at reset values, counters 0, sequence restarts with a full 12-cycle pll_resetb pulse.
- Saturation: CNT_W=2, force 5 lock losses -> lock_loss_count holds at 3; one timeout followed by a successful lock -> retry_count returns to 0 on entry to RUN.
